// File: rtl/onchip_ram_arb_pkg.sv
// Shared types for the on-chip RAM arbiter.
// Optional grant statistics: ONCHIP_RAM_ARB_STATS_EN.
package onchip_ram_arb_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 32;
  localparam int HOLD_MAX_LIMIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_e;

  typedef logic req_idx_t;

  function automatic arb_state_e own_state(
    input req_idx_t idx
  );
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/onchip_ram_arb_rr.sv
// Round-robin grant FSM with a bounded hold window.
// Grant is combinational for the current cycle.
module onchip_ram_arb_rr
  import onchip_ram_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  arb_state_e state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  req_idx_t   last_q, last_d;
  req_idx_t   win;
  req_idx_t   cur;
  req_idx_t   oth;
  logic       gnt_v;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    win        = 1'b0;
    gnt_v      = 1'b0;
    cur        = (state_q == OWN1);
    oth        = ~cur;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win        = (&req) ? ~last_q : req[1];
          gnt_v      = 1'b1;
          state_d    = own_state(win);
          hold_cnt_d = 4'd1;
        end
      end
      OWN0, OWN1: begin
        if (req[cur]) begin
          gnt_v = 1'b1;
          if (req[oth] && hold_cnt_q >= HOLD_LIM) begin
            win        = oth;
            state_d    = own_state(oth);
            hold_cnt_d = 4'd1;
            last_d     = cur;
          end else begin
            win = cur;
            if (hold_cnt_q < HOLD_LIM) begin
              hold_cnt_d = hold_cnt_q + 4'd1;
            end
          end
        end else if (req[oth]) begin
          // Owner dropped: hand over with no bubble.
          win        = oth;
          gnt_v      = 1'b1;
          state_d    = own_state(oth);
          hold_cnt_d = 4'd1;
          last_d     = cur;
        end else begin
          state_d    = IDLE;
          hold_cnt_d = 4'd0;
          last_d     = cur;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (gnt_v && rst_n) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-requester Avalon-MM arbiter for a single-port RAM.
// Grant statistics enabled by ONCHIP_RAM_ARB_STATS_EN.
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic [DATA_W-1:0]   r0_writedata,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic [DATA_W-1:0]   r1_writedata,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [31:0]         stat_grant0,
  output logic [31:0]         stat_grant1
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       rd_pend_q, rd_pend_d;
  req_idx_t   rd_owner_q, rd_owner_d;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  onchip_ram_arb_rr #(
    .HOLD_MAX (HOLD_MAX)
  ) u_rr (
    .clk   (clk),
    .rst_n (reset_n),
    .req   (req),
    .grant (grant)
  );

  assign r0_waitrequest = req[0] & ~grant[0];
  assign r1_waitrequest = req[1] & ~grant[1];

  assign ram_address    = grant[1] ? r1_address : r0_address;
  assign ram_byteenable = grant[1] ? r1_byteenable : r0_byteenable;
  assign ram_writedata  = grant[1] ? r1_writedata : r0_writedata;
  assign ram_chipselect = |(grant & req);
  assign ram_write      = grant[1] ? r1_write : (grant[0] & r0_write);
  assign ram_clken      = reset_n;

  // Write wins when read and write collide on one requester.
  always_comb begin
    rd_pend_d  = (grant[0] & r0_read & ~r0_write)
               | (grant[1] & r1_read & ~r1_write);
    rd_owner_d = grant[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign r0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign r1_readdatavalid = rd_pend_q & rd_owner_q;
  assign r0_readdata = r0_readdatavalid ? ram_readdata : '0;
  assign r1_readdata = r1_readdatavalid ? ram_readdata : '0;

`ifdef ONCHIP_RAM_ARB_STATS_EN
  logic [31:0] stat0_q, stat0_d;
  logic [31:0] stat1_q, stat1_d;

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (grant[0] && stat0_q != '1) begin
      stat0_d = stat0_q + 32'd1;
    end
    if (grant[1] && stat1_q != '1) begin
      stat1_d = stat1_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat_grant0 = stat0_q;
  assign stat_grant1 = stat1_q;
`else
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
`endif

  a_r0_rw: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(r0_read && r0_write)
  );

  a_r1_rw: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(r1_read && r1_write)
  );

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed self-checking bench for onchip_ram_arbiter.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] r0_address, r1_address;
  logic        r0_read, r0_write;
  logic        r1_read, r1_write;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;
  logic [31:0] stat_grant0, stat_grant1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_ram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .r0_address       (r0_address),
    .r0_read          (r0_read),
    .r0_write         (r0_write),
    .r0_byteenable    (r0_byteenable),
    .r0_writedata     (r0_writedata),
    .r0_waitrequest   (r0_waitrequest),
    .r0_readdata      (r0_readdata),
    .r0_readdatavalid (r0_readdatavalid),
    .r1_address       (r1_address),
    .r1_read          (r1_read),
    .r1_write         (r1_write),
    .r1_byteenable    (r1_byteenable),
    .r1_writedata     (r1_writedata),
    .r1_waitrequest   (r1_waitrequest),
    .r1_readdata      (r1_readdata),
    .r1_readdatavalid (r1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .stat_grant0      (stat_grant0),
    .stat_grant1      (stat_grant1)
  );

  // Unwritten words read back as a recognisable pattern.
  function automatic logic [31:0] pat(input logic [11:0] a);
    return {16'hC0DE, 4'h0, a};
  endfunction

  logic [31:0]   mem [4096];
  logic [4095:0] written = '0;

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      logic [31:0] w;
      w = written[ram_address] ? mem[ram_address]
                               : pat(ram_address);
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) w[8*b+:8] = ram_writedata[8*b+:8];
        end
        mem[ram_address]     <= w;
        written[ram_address] <= 1'b1;
      end else begin
        ram_readdata <= w;
      end
    end
  end

  task automatic set_idle();
    r0_address = '0; r0_read = 0; r0_write = 0;
    r0_byteenable = 4'hF; r0_writedata = '0;
    r1_address = '0; r1_read = 0; r1_write = 0;
    r1_byteenable = 4'hF; r1_writedata = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_chipselect, ram_write, ram_clken} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ram got=%b exp=000",
               {ram_chipselect, ram_write, ram_clken});
    end
    checks++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=00",
               {r0_readdatavalid, r1_readdatavalid});
    end
    reset_n = 1'b1;
    // Reset in the middle of a pending read.
    @(posedge clk); #1;
    r0_read = 1; r0_address = 12'h020;
    @(posedge clk); #1;
    r0_read = 0;
    checks++;
    if (r0_readdatavalid !== 1'b1) begin
      failures++;
      $display("FAIL pend_valid got=%b exp=1", r0_readdatavalid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (r0_readdatavalid !== 1'b0 || r0_readdata !== 32'h0) begin
      failures++;
      $display("FAIL midrd_drop got=%b/%h exp=0/0",
               r0_readdatavalid, r0_readdata);
    end
    checks++;
    if ({ram_chipselect, ram_write, ram_clken} !== 3'b000) begin
      failures++;
      $display("FAIL midrd_ram got=%b exp=000",
               {ram_chipselect, ram_write, ram_clken});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (r0_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL midrd_hold got=%b exp=0", r0_readdatavalid);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    r0_read = 1; r0_address = 12'h010;
    @(negedge clk);
    checks++;
    if (ram_chipselect !== 1'b1 || ram_address !== 12'h010
        || r0_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL first_rd cs=%b a=%h wr=%b exp 1/010/0",
               ram_chipselect, ram_address, r0_waitrequest);
    end
    checks++;
    if (ram_clken !== 1'b1) begin
      failures++;
      $display("FAIL clken got=%b exp=1", ram_clken);
    end
    @(posedge clk); #1;
    r0_read = 0;
    @(negedge clk);
    checks++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'hC0DE0010) begin
      failures++;
      $display("FAIL first_rdv got=%b/%h exp=1/c0de0010",
               r0_readdatavalid, r0_readdata);
    end
    checks++;
    if (r1_readdatavalid !== 1'b0 || r1_readdata !== 32'h0) begin
      failures++;
      $display("FAIL other_rd got=%b/%h exp=0/0",
               r1_readdatavalid, r1_readdata);
    end
  endtask

  task automatic test_solo_stream();
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      r0_read    = (i < 8);
      r0_address = 12'(i);
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (r0_waitrequest !== 1'b0) begin
          failures++;
          $display("FAIL stream_wait i=%0d got=%b exp=0",
                   i, r0_waitrequest);
        end
      end
      if (i > 0) begin
        checks++;
        if (r0_readdatavalid !== 1'b1
            || r0_readdata !== pat(12'(i - 1))) begin
          failures++;
          $display("FAIL stream_data i=%0d got=%b/%h exp=1/%h",
                   i, r0_readdatavalid, r0_readdata, pat(12'(i - 1)));
        end
      end
    end
    set_idle();
  endtask

  task automatic test_contention();
    logic [11:0] seq;
    logic        w;
    logic        p;
    seq = 12'b0000_1111_0000;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      r0_read = (k < 12); r0_address = 12'h100;
      r1_read = (k < 12); r1_address = 12'h200;
      @(negedge clk);
      if (k < 12) begin
        w = seq[k];
        checks++;
        if (r0_waitrequest !== w || r1_waitrequest !== ~w) begin
          failures++;
          $display("FAIL cont_wait k=%0d got=%b%b exp=%b%b",
                   k, r1_waitrequest, r0_waitrequest, ~w, w);
        end
      end
      if (k > 0) begin
        p = seq[k-1];
        checks++;
        if (r0_readdatavalid !== ~p || r1_readdatavalid !== p) begin
          failures++;
          $display("FAIL cont_valid k=%0d got=%b%b exp=%b%b",
                   k, r1_readdatavalid, r0_readdatavalid, p, ~p);
        end
        checks++;
        if (ram_readdata !== (p ? 32'hC0DE0200 : 32'hC0DE0100)) begin
          failures++;
          $display("FAIL cont_data k=%0d got=%h", k, ram_readdata);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_tie();
    do_reset();
    @(posedge clk); #1;
    r0_write = 1; r0_address = 12'h050; r0_writedata = 32'h11111111;
    r1_write = 1; r1_address = 12'h051; r1_writedata = 32'h22222222;
    @(negedge clk);
    checks++;
    if (r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL tie_wait got=%b%b exp=10",
               r1_waitrequest, r0_waitrequest);
    end
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 12'h050) begin
      failures++;
      $display("FAIL tie_ram0 got=%b/%h exp=1/050",
               ram_write, ram_address);
    end
    @(posedge clk); #1;
    r0_write = 0;
    @(negedge clk);
    checks++;
    if (r1_waitrequest !== 1'b0 || ram_chipselect !== 1'b1) begin
      failures++;
      $display("FAIL tie_r1 got=%b/%b exp=0/1",
               r1_waitrequest, ram_chipselect);
    end
    checks++;
    if (ram_address !== 12'h051 || ram_writedata !== 32'h22222222) begin
      failures++;
      $display("FAIL tie_ram1 got=%h/%h exp=051/22222222",
               ram_address, ram_writedata);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (ram_chipselect !== 1'b0 || r1_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL tie_idle got=%b/%b exp=0/0",
               ram_chipselect, r1_readdatavalid);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    r1_write = 1; r1_address = 12'h3FF;
    r1_writedata = 32'hDEADBEEF; r1_byteenable = 4'b0011;
    @(negedge clk);
    checks++;
    if (ram_byteenable !== 4'b0011 || ram_write !== 1'b1) begin
      failures++;
      $display("FAIL wr_be got=%b/%b exp=0011/1",
               ram_byteenable, ram_write);
    end
    @(posedge clk); #1;
    r1_write = 0;
    r0_read = 1; r0_address = 12'h3FF;
    @(negedge clk);
    checks++;
    if (r0_waitrequest !== 1'b0 || ram_write !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_wr got=%b/%b exp=0/0",
               r0_waitrequest, ram_write);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (r0_readdatavalid !== 1'b1 || r0_readdata !== 32'hC0DEBEEF) begin
      failures++;
      $display("FAIL wr_rd_data got=%b/%h exp=1/c0debeef",
               r0_readdatavalid, r0_readdata);
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      r0_read = (i < 5); r0_address = 12'h300;
      r1_read = (i >= 5); r1_address = 12'h301;
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
`ifdef ONCHIP_RAM_ARB_STATS_EN
    checks++;
    if (stat_grant0 !== 32'd5 || stat_grant1 !== 32'd3) begin
      failures++;
      $display("FAIL stat_count got=%0d/%0d exp=5/3",
               stat_grant0, stat_grant1);
    end
    force dut.stat0_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    r0_read = 1;
    @(negedge clk);
    release dut.stat0_q;
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++;
    if (stat_grant0 !== 32'hFFFF_FFFF || stat_grant1 !== 32'd3) begin
      failures++;
      $display("FAIL stat_sat got=%h/%0d exp=ffffffff/3",
               stat_grant0, stat_grant1);
    end
`else
    checks++;
    if (stat_grant0 !== 32'd0 || stat_grant1 !== 32'd0) begin
      failures++;
      $display("FAIL stat_off got=%0d/%0d exp=0/0",
               stat_grant0, stat_grant1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_solo_stream();
    test_contention();
    test_tie();
    test_write_read();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Shares one single-port 4096x32 on-chip RAM (1-cycle read latency, byte enables) between two Avalon-MM requesters: requester 0 (Nios II data master) and requester 1 (counter/DMA engine).
- Grants at most one access per cycle.
- Round-robin with a bounded hold window.
- Returns read data to the issuing requester with readdatavalid.

Parameters:
- ADDR_W, 12, word address width
- DATA_W, 32, data width (byte enables = DATA_W/8)
- HOLD_MAX, 4, max consecutive beats an owner keeps the grant while the other requester waits (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- r0_address / r1_address  in  ADDR_W  requester word address
- r0_read / r1_read  in  1  read request
- r0_write / r1_write  in  1  write request
- r0_byteenable / r1_byteenable  in  DATA_W/8  byte lanes
- r0_writedata / r1_writedata  in  DATA_W  write data
- r0_waitrequest / r1_waitrequest  out  1  request not accepted this cycle
- r0_readdata / r1_readdata  out  DATA_W  read data
- r0_readdatavalid / r1_readdatavalid  out  1  read data valid
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM
- ram_chipselect  out  1  access strobe
- ram_write  out  1  write strobe
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  tied 1 except while reset_n low
- ram_readdata  in  DATA_W  RAM output, valid the cycle after the address edge
- stat_grant0 / stat_grant1  out  32  grant counters (see Optional Feature)

Behaviour:
- Request: reqN = rN_read | rN_write. read and write both high on one requester is illegal; write wins and an assertion fires.
- Acceptance: a request is accepted on the rising edge where reqN=1 and rN_waitrequest=0. waitrequestN = reqN & ~grantN (combinational). Idle requesters see waitrequest=0.
- Grant FSM states IDLE, OWN0, OWN1; registers owner_q, hold_cnt_q (4 bit), last_q (last winner).
  - IDLE: if only one requests, grant it and go to OWNx with hold_cnt=1. If both request, grant ~last_q.
  - OWNx, x still requesting, other idle: keep grant; hold_cnt saturates at HOLD_MAX.
  - OWNx, x still requesting, other requesting, hold_cnt<HOLD_MAX: keep grant, hold_cnt++.
  - OWNx, x still requesting, other requesting, hold_cnt=HOLD_MAX: switch to other, hold_cnt=1, last_q=x.
  - OWNx, x drops, other requests: switch to other in the same cycle (no bubble).
  - OWNx, neither requests: go to IDLE; last_q=x.
- RAM mux: ram_* driven combinationally from the granted requester. ram_chipselect = grant & req. ram_write = granted write.
- Read return: registered rd_pend_q, rd_owner_q set on an accepted read. Next cycle, rN_readdatavalid=1 for the owner and rN_readdata=ram_readdata. The other requester's readdata holds 0.
- Throughput: back-to-back reads from alternating requesters sustain 1 access/cycle.
- Write/read same address on consecutive cycles: the read returns the new data (RAM is single-port, sequential).
- Reset (async, any cycle): FSM=IDLE, last_q=1 (so requester 0 wins the first tie), hold_cnt=0, rd_pend=0. All readdatavalid=0, readdata=0, ram_chipselect=0, ram_write=0, ram_clken=0. An in-flight read is dropped with no valid pulse. Outputs deassert immediately on reset_n fall.
- Synchronous deassertion of reset_n is the integrator's responsibility.

Optional Feature:
- Macro: ONCHIP_RAM_ARB_STATS_EN.
- Defined: stat_grant0/1 count accepted accesses per requester. 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: no counter logic; stat_grant0/1 tied to 0.

Decomposition:
- Shared package onchip_ram_arb_pkg holds:
  - FSM state enum (IDLE/OWN0/OWN1)
  - requester index type
  - default widths ADDR_W=12, DATA_W=32
  - HOLD_MAX_LIMIT=15
- One natural sub-module: onchip_ram_arb_rr. Contains the FSM, hold counter and last_q; outputs a one-hot grant. The RAM mux and read-return registers stay in the top.

Test Plan:
- Reset: reset_n low mid-read (rd_pend=1) -> no readdatavalid pulse, all outputs 0. After release, r0 read addr 0x010 -> ram_chipselect same cycle, r0_readdatavalid next cycle with RAM content.
- Solo streaming: r0 issues 8 back-to-back reads 0x000-0x007 -> waitrequest never high, 8 consecutive valid pulses in address order.
- Contention, HOLD_MAX=4: both request continuously from IDLE -> grant sequence r0 x4, r1 x4, r0 x4. The waiter's waitrequest stays high until its turn.
- Tie after reset: both assert a write in the same cycle -> r0 granted first; r1 granted the next cycle if r0 drops.
- Write-then-read: r1 write 0xDEADBEEF with byteenable 0b0011 to 0x3FF, then r0 reads 0x3FF -> returns old[31:16] concatenated with 0xBEEF.
- Stats (macro defined): 5 r0 and 3 r1 accepted accesses -> stat_grant0=5, stat_grant1=3. Counter preloaded via force at 0xFFFFFFFF stays saturated.
